// File: rtl/alu_md_pkg.sv
// ALU control encodings, funct codes and mul/div FSM states
// shared by the EX-stage ALU control and its mul/div datapath.
package alu_md_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0011;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_SUB   = 2'b01;
   localparam logic [1:0] OP_RTYPE = 2'b10;
   localparam logic [1:0] OP_AND   = 2'b11;

   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_XOR   = 6'b100110;
   localparam logic [5:0] F_NOR   = 6'b100111;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } md_state_e;

   function automatic logic is_md(input logic [5:0] f);
      return (f == F_MULT) || (f == F_MULTU) ||
             (f == F_DIV)  || (f == F_DIVU);
   endfunction

   function automatic logic is_mf(input logic [5:0] f);
      return (f == F_MFHI) || (f == F_MFLO);
   endfunction

   function automatic logic is_mt(input logic [5:0] f);
      return (f == F_MTHI) || (f == F_MTLO);
   endfunction

endpackage

// File: rtl/alu_control_md_md_iter.sv
// Iterative multiply / restoring divide: one bit per cycle on
// magnitudes, sign correction applied in the FIX state.
module md_iter
   import alu_md_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             start,
   input  logic             is_div,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi_res,
   output logic [WIDTH-1:0] lo_res,
   output logic             busy,
   output logic             done
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   md_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               div_q, div_d;
   logic               neg_q, neg_d;
   logic               sa_q, sa_d;
   logic               dz_q, dz_d;

   logic               load;
   logic               sa, sb;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_tmp;
   logic [WIDTH:0]     div_sub;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] prod_neg;
   logic [WIDTH-1:0]   quo, rem;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // next state: flush aborts RUN/FIX, FIX always returns to IDLE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (start && !flush) state_d = RUN;
         RUN: begin
            if (flush)              state_d = IDLE;
            else if (cnt_q == LAST) state_d = FIX;
         end
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy = (state_q != IDLE);
      done = (state_q == FIX);
   end

   // one shift-add or one restoring-subtract step on the shared register
   always_comb begin
      load  = (state_q == IDLE) && start && !flush;
      sa    = is_signed && a[WIDTH-1];
      sb    = is_signed && b[WIDTH-1];
      a_abs = sa ? -a : a;
      b_abs = sb ? -b : b;

      mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                 (prod_q[0] ? {1'b0, b_q} : '0);
      mul_next = {mul_sum, prod_q[WIDTH-1:1]};

      div_tmp  = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
      div_sub  = div_tmp - {1'b0, b_q};
      div_next = (div_tmp >= {1'b0, b_q}) ?
                 {div_sub[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1} :
                 {div_tmp[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
   end

   // datapath next-state
   always_comb begin
      cnt_d  = cnt_q;
      prod_d = prod_q;
      a_d    = a_q;
      b_d    = b_q;
      div_d  = div_q;
      neg_d  = neg_q;
      sa_d   = sa_q;
      dz_d   = dz_q;
      if (load) begin
         cnt_d  = '0;
         prod_d = {{WIDTH{1'b0}}, a_abs};
         a_d    = a_abs;
         b_d    = b_abs;
         div_d  = is_div;
         neg_d  = sa ^ sb;
         sa_d   = sa;
         dz_d   = (b == '0);
      end else if (state_q == RUN) begin
         cnt_d  = cnt_q + CNT_W'(1);
         prod_d = div_q ? div_next : mul_next;
      end
   end

   // datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         prod_q <= '0;
         a_q    <= '0;
         b_q    <= '0;
         div_q  <= 1'b0;
         neg_q  <= 1'b0;
         sa_q   <= 1'b0;
         dz_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         prod_q <= prod_d;
         a_q    <= a_d;
         b_q    <= b_d;
         div_q  <= div_d;
         neg_q  <= neg_d;
         sa_q   <= sa_d;
         dz_q   <= dz_d;
      end
   end

   // sign correction; divide by zero returns the dividend and all ones
   always_comb begin
      prod_neg = -prod_q;
      quo      = prod_q[WIDTH-1:0];
      rem      = prod_q[2*WIDTH-1:WIDTH];
      hi_res   = '0;
      lo_res   = '0;
      if (!div_q) begin
         {hi_res, lo_res} = neg_q ? prod_neg : prod_q;
      end else if (dz_q) begin
         hi_res = sa_q ? -a_q : a_q;
         lo_res = '1;
      end else begin
         lo_res = neg_q ? -quo : quo;
         hi_res = sa_q ? -rem : rem;
      end
   end

endmodule

// File: rtl/alu_control_md.sv
// EX-stage ALU control with HI/LO registers and a multicycle
// mul/div unit that stalls the front of the pipe while busy.
module alu_control_md
   import alu_md_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   input  logic             flush,
   input  logic [1:0]       ALUOp,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   output logic [3:0]       ALUCtrl,
   output logic             use_hilo,
   output logic [WIDTH-1:0] hilo_data,
   output logic             stall,
   output logic             md_busy,
   output logic             md_done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] hi_res, lo_res;
   logic             rtype;
   logic             issue;
   logic             busy;
   logic             done;

   // ALU operation decode, independent of valid_in
   always_comb begin
      ALUCtrl = ALU_AND;
      unique case (ALUOp)
         OP_ADD: ALUCtrl = ALU_ADD;
         OP_SUB: ALUCtrl = ALU_SUB;
         OP_AND: ALUCtrl = ALU_AND;
         OP_RTYPE: begin
            unique case (funct)
               F_ADD:   ALUCtrl = ALU_ADD;
               F_SUB:   ALUCtrl = ALU_SUB;
               F_AND:   ALUCtrl = ALU_AND;
               F_OR:    ALUCtrl = ALU_OR;
               F_XOR:   ALUCtrl = ALU_XOR;
               F_NOR:   ALUCtrl = ALU_NOR;
               F_SLT:   ALUCtrl = ALU_SLT;
               default: ALUCtrl = ALU_AND;
            endcase
         end
         default: ALUCtrl = ALU_AND;
      endcase
   end

   // HI/LO op qualification, stall and issue
   always_comb begin
      rtype    = valid_in && (ALUOp == OP_RTYPE);
      stall    = rtype && (is_md(funct) || is_mf(funct) ||
                 is_mt(funct)) && busy && !flush;
      issue    = rtype && is_md(funct) && !busy && !flush;
      md_busy  = busy;
      md_done  = done && !flush;
      use_hilo = rtype && is_mf(funct);
      hilo_data = '0;
      if (rtype && funct == F_MFHI) hilo_data = hi_q;
      if (rtype && funct == F_MFLO) hilo_data = lo_q;
   end

   md_iter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_md_iter (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .start     (issue),
      .is_div    (funct[1]),
      .is_signed (!funct[0]),
      .a         (opA),
      .b         (opB),
      .hi_res    (hi_res),
      .lo_res    (lo_res),
      .busy      (busy),
      .done      (done)
   );

   // HI/LO update: mul/div result at end of FIX, else MTHI/MTLO
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (md_done) begin
         hi_d = hi_res;
         lo_d = lo_res;
      end else if (rtype && !busy && !flush) begin
         if (funct == F_MTHI) hi_d = opA;
         if (funct == F_MTLO) lo_d = opA;
      end
   end

   // HI/LO registers
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: tb/tb_alu_control_md.sv
// Scoreboard bench for alu_control_md: decode sweep, mul/div
// results and latency, stall, MT/MF, flush and reset.
module tb_alu_control_md;

   localparam logic [5:0] MULT  = 6'b011000;
   localparam logic [5:0] MULTU = 6'b011001;
   localparam logic [5:0] DIV   = 6'b011010;
   localparam logic [5:0] DIVU  = 6'b011011;
   localparam logic [5:0] MFHI  = 6'b010000;
   localparam logic [5:0] MTHI  = 6'b010001;
   localparam logic [5:0] MFLO  = 6'b010010;
   localparam logic [5:0] MTLO  = 6'b010011;

   logic        clk;
   logic        rst;
   logic        valid_in;
   logic        flush;
   logic [1:0]  ALUOp;
   logic [5:0]  funct;
   logic [31:0] opA;
   logic [31:0] opB;
   logic [3:0]  ALUCtrl;
   logic        use_hilo;
   logic [31:0] hilo_data;
   logic        stall;
   logic        md_busy;
   logic        md_done;
   logic [31:0] hi;
   logic [31:0] lo;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [63:0] sbq[$];
   logic [63:0] pexp;
   logic        pend = 1'b0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   alu_control_md #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (valid_in),
      .flush     (flush),
      .ALUOp     (ALUOp),
      .funct     (funct),
      .opA       (opA),
      .opB       (opB),
      .ALUCtrl   (ALUCtrl),
      .use_hilo  (use_hilo),
      .hilo_data (hilo_data),
      .stall     (stall),
      .md_busy   (md_busy),
      .md_done   (md_done),
      .hi        (hi),
      .lo        (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [5:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      logic signed [63:0] sa, sb, p;
      logic signed [31:0] q, r;
      case (f)
         MULT: begin
            sa = $signed(a);
            sb = $signed(b);
            p  = sa * sb;
            return p;
         end
         MULTU: return {32'b0, a} * {32'b0, b};
         DIV: begin
            if (b == 0) return {a, 32'hFFFFFFFF};
            if (a == 32'h80000000 && b == 32'hFFFFFFFF)
               return {32'h0, 32'h80000000};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {r, q};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFFFFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   // scoreboard: pop on md_done, compare HI/LO after the write edge
   always @(negedge clk) begin
      if (pend) begin
         chk("sb_hi", {32'b0, hi}, {32'b0, pexp[63:32]});
         chk("sb_lo", {32'b0, lo}, {32'b0, pexp[31:0]});
         pend = 1'b0;
      end
      if (md_done) begin
         if (sbq.size() == 0) begin
            chk("done_unexp", 64'd1, 64'd0);
         end else begin
            pexp = sbq.pop_front();
            pend = 1'b1;
         end
      end
   end

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   // hold the op while stalled, then push the model result on issue
   task automatic issue(input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic push,
                        output int st);
      logic [63:0] e;
      valid_in = 1'b1;
      ALUOp    = 2'b10;
      funct    = f;
      opA      = a;
      opB      = b;
      st       = 0;
      #5;
      while (stall && st < 200) begin
         next_cyc();
         #5;
         st++;
      end
      if (st >= 200) chk("issue_timeout", 64'd1, 64'd0);
      if (push) begin
         e = model(f, a, b);
         sbq.push_back(e);
         {m_hi, m_lo} = e;
      end
      next_cyc();
      valid_in = 1'b0;
      funct    = '0;
      opA      = '0;
      opB      = '0;
   endtask

   task automatic wait_done(output int lat);
      logic found;
      found = 1'b0;
      lat   = 0;
      for (int k = 1; k <= 200; k++) begin
         #5;
         if (md_done) begin
            lat   = k;
            found = 1'b1;
            chk("busy_in_fix", {63'b0, md_busy}, 64'd1);
            next_cyc();
            break;
         end
         next_cyc();
      end
      if (!found) chk("done_timeout", 64'd1, 64'd0);
   endtask

   task automatic run_op(input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b);
      int st, lat;
      issue(f, a, b, 1'b1, st);
      chk("issue_stall", st, 0);
      wait_done(lat);
      chk("latency", lat, 33);
      #5;
      chk("busy_after", {63'b0, md_busy}, 64'd0);
      next_cyc();
   endtask

   logic [1:0] d_op [12] = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b00, 2'b11,
                             2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
   logic [5:0] d_fn [12] = '{6'b100111, 6'b100110, 6'b000000, 6'b011000,
                             6'b000000, 6'b000000, 6'b100000, 6'b100010,
                             6'b101010, 6'b100101, 6'b100100, 6'b010000};
   logic [3:0] d_ex [12] = '{4'b1100, 4'b0011, 4'b0110, 4'b0000,
                             4'b0010, 4'b0000, 4'b0010, 4'b0110,
                             4'b0111, 4'b0001, 4'b0000, 4'b0000};

   initial begin
      int st, st2, lat, nst, kk;
      logic [5:0]  rf;
      logic [31:0] ra, rb;
      rst = 1'b1; valid_in = 1'b0; flush = 1'b0;
      ALUOp = '0; funct = '0; opA = '0; opB = '0;
      repeat (2) next_cyc();
      rst = 1'b0;
      #5;
      chk("rst_hi", {32'b0, hi}, 64'd0);
      chk("rst_lo", {32'b0, lo}, 64'd0);
      chk("rst_busy", {63'b0, md_busy}, 64'd0);
      chk("rst_done", {63'b0, md_done}, 64'd0);
      chk("rst_stall", {63'b0, stall}, 64'd0);
      next_cyc();

      for (int i = 0; i < 12; i++) begin
         ALUOp = d_op[i];
         funct = d_fn[i];
         #1;
         chk($sformatf("decode%0d", i), {60'b0, ALUCtrl}, {60'b0, d_ex[i]});
      end
      ALUOp = '0; funct = '0;
      next_cyc();

      run_op(MULT, -32'sd3, 32'd7);
      #5;
      chk("mult_hi", {32'b0, hi}, {32'b0, 32'hFFFFFFFF});
      chk("mult_lo", {32'b0, lo}, {32'b0, 32'hFFFFFFEB});
      next_cyc();
      run_op(DIV, -32'sd7, 32'd2);
      #5;
      chk("div_lo", {32'b0, lo}, {32'b0, 32'hFFFFFFFD});
      chk("div_hi", {32'b0, hi}, {32'b0, 32'hFFFFFFFF});
      next_cyc();
      run_op(DIVU, 32'd5, 32'd0);
      #5;
      chk("divu0_lo", {32'b0, lo}, {32'b0, 32'hFFFFFFFF});
      chk("divu0_hi", {32'b0, hi}, 64'd5);
      next_cyc();
      run_op(DIV, -32'sd9, 32'd0);
      run_op(DIV, 32'h80000000, 32'hFFFFFFFF);
      run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      run_op(DIVU, 32'd100, 32'd7);
      run_op(MULT, 32'h80000000, 32'h80000000);

      // MFLO while busy
      issue(MULT, 32'd6, -32'sd5, 1'b1, st);
      repeat (4) next_cyc();
      valid_in = 1'b1; ALUOp = 2'b10; funct = MFLO;
      nst = 0;
      for (kk = 5; kk <= 60; kk++) begin
         #5;
         if (!stall) break;
         nst++;
         next_cyc();
      end
      chk("mflo_stall_cycles", nst, 29);
      chk("mflo_use", {63'b0, use_hilo}, 64'd1);
      chk("mflo_data", {32'b0, hilo_data}, {32'b0, 32'hFFFFFFE2});
      next_cyc();
      valid_in = 1'b0; funct = '0;

      // MTHI/MTLO then MFHI/MFLO
      valid_in = 1'b1; ALUOp = 2'b10; funct = MTHI; opA = 32'd1234;
      next_cyc();
      funct = MFHI; opA = '0;
      m_hi = 32'd1234;
      #5;
      chk("mfhi_stall", {63'b0, stall}, 64'd0);
      chk("mfhi_use", {63'b0, use_hilo}, 64'd1);
      chk("mfhi_data", {32'b0, hilo_data}, {32'b0, m_hi});
      next_cyc();
      funct = MTLO; opA = 32'h5A5A0001;
      next_cyc();
      funct = MFLO; opA = '0;
      m_lo = 32'h5A5A0001;
      #5;
      chk("mflo_mt_data", {32'b0, hilo_data}, {32'b0, m_lo});
      next_cyc();

      // flush suppresses MTHI
      funct = MTHI; opA = 32'd777; flush = 1'b1;
      next_cyc();
      flush = 1'b0; funct = MFHI; opA = '0;
      #5;
      chk("mt_flush", {32'b0, hilo_data}, {32'b0, m_hi});
      next_cyc();

      // flush wins over simultaneous issue
      funct = MULT; opA = 32'd3; opB = 32'd3; flush = 1'b1;
      next_cyc();
      flush = 1'b0; valid_in = 1'b0; funct = '0;
      #5;
      chk("issue_flush_busy", {63'b0, md_busy}, 64'd0);
      next_cyc();

      // DIV flushed at T+10
      issue(DIV, 32'd100, 32'd3, 1'b0, st);
      repeat (9) next_cyc();
      valid_in = 1'b1; ALUOp = 2'b10; funct = MFHI; flush = 1'b1;
      #5;
      chk("stall_flush", {63'b0, stall}, 64'd0);
      next_cyc();
      valid_in = 1'b0; flush = 1'b0; funct = '0;
      #5;
      chk("flush_busy", {63'b0, md_busy}, 64'd0);
      chk("flush_hi", {32'b0, hi}, {32'b0, m_hi});
      chk("flush_lo", {32'b0, lo}, {32'b0, m_lo});
      repeat (40) next_cyc();
      chk("flush_hi_late", {32'b0, hi}, {32'b0, m_hi});

      // reset at T+20 of a MULTU
      issue(MULTU, 32'hDEADBEEF, 32'h1234, 1'b0, st);
      repeat (19) next_cyc();
      rst = 1'b1;
      next_cyc();
      rst = 1'b0;
      m_hi = '0; m_lo = '0;
      #5;
      chk("rst_mid_hi", {32'b0, hi}, 64'd0);
      chk("rst_mid_lo", {32'b0, lo}, 64'd0);
      chk("rst_mid_busy", {63'b0, md_busy}, 64'd0);
      next_cyc();

      // back-to-back MULTU
      issue(MULTU, 32'h0001_0003, 32'h0002_0005, 1'b1, st);
      issue(MULTU, 32'hCAFE_F00D, 32'h1357_9BDF, 1'b1, st2);
      chk("b2b_first_stall", st, 0);
      chk("b2b_second_stall", st2, 33);
      wait_done(lat);
      chk("b2b_latency", lat, 33);
      next_cyc();

      for (int i = 0; i < 6; i++) begin
         rf = MULT | 6'($urandom_range(0, 3));
         ra = $urandom;
         rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15))
                                          : $urandom;
         run_op(rf, ra, rb);
      end

      repeat (3) next_cyc();
      chk("sb_empty", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
